// File: rtl/hazard_controller_if.sv
// Pipeline-side view of the hazard controller: register addresses and hazard
// inputs from ID/EX/MEM/WB, plus the stall/flush/forward controls sent back.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1d_i;
    logic [4:0]       rs2d_i;
    logic [4:0]       rs1e_i;
    logic [4:0]       rs2e_i;
    logic [4:0]       rde_i;
    logic             loade_i;
    logic             pcsrce_i;
    logic [4:0]       rdm_i;
    logic             regwritem_i;
    logic             memaccessm_i;
    logic [4:0]       rdw_i;
    logic             regwritew_i;
    logic [1:0]       forwardae_o;
    logic [1:0]       forwardbe_o;
    logic             stallf_o;
    logic             stalld_o;
    logic             stalle_o;
    logic             stallm_o;
    logic             flushd_o;
    logic             flushe_o;
    logic             flushw_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             wait_state_o;

    // All handshakes here are level signals sampled every cycle; there is no
    // valid/ready pair, the pipeline simply obeys the stall/flush levels.
    modport master (
        output rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, loade_i, pcsrce_i,
        output rdm_i, regwritem_i, memaccessm_i, rdw_i, regwritew_i,
        input  forwardae_o, forwardbe_o, stallf_o, stalld_o, stalle_o, stallm_o,
        input  flushd_o, flushe_o, flushw_o, stall_cnt_o, wait_state_o
    );

    modport slave (
        input  rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, loade_i, pcsrce_i,
        input  rdm_i, regwritem_i, memaccessm_i, rdw_i, regwritew_i,
        output forwardae_o, forwardbe_o, stallf_o, stalld_o, stalle_o, stallm_o,
        output flushd_o, flushe_o, flushw_o, stall_cnt_o, wait_state_o
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, load-use
// stall, branch flush and a wait-state FSM for multi-cycle data memory.
module hazard_controller #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 32
) (
    input logic          clk_i,
    input logic          reset_i,
    hazard_controller_if.slave hz
);
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_busy;
    logic             lwstall;
    logic             stallf;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wm,
                                           input logic [4:0] rdw, input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs)
            return 2'b10;
        else if (ww && rdw != 5'd0 && rdw == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        mem_busy = (state == IDLE) ? (hz.memaccessm_i && (MEM_WAIT != 0)) : (cnt != '0);
        lwstall  = hz.loade_i && (hz.rde_i != 5'd0) &&
                   (hz.rde_i == hz.rs1d_i || hz.rde_i == hz.rs2d_i) && !hz.pcsrce_i;
    end

    // Reset forces every control to its inactive value, even mid-wait.
    always_comb begin
        hz.forwardae_o = 2'b00;
        hz.forwardbe_o = 2'b00;
        stallf         = 1'b0;
        hz.stalld_o    = 1'b0;
        hz.stalle_o    = 1'b0;
        hz.stallm_o    = 1'b0;
        hz.flushd_o    = 1'b0;
        hz.flushe_o    = 1'b0;
        hz.flushw_o    = 1'b0;
        if (reset_i) begin
            hz.forwardae_o = fwd_sel(hz.rs1e_i, hz.rdm_i, hz.regwritem_i, hz.rdw_i, hz.regwritew_i);
            hz.forwardbe_o = fwd_sel(hz.rs2e_i, hz.rdm_i, hz.regwritem_i, hz.rdw_i, hz.regwritew_i);
            if (mem_busy) begin
                // A branch in EX stays frozen; its flush fires on the release cycle.
                stallf      = 1'b1;
                hz.stalld_o = 1'b1;
                hz.stalle_o = 1'b1;
                hz.stallm_o = 1'b1;
                hz.flushw_o = 1'b1;
            end else begin
                stallf      = lwstall;
                hz.stalld_o = lwstall;
                hz.flushe_o = lwstall | hz.pcsrce_i;
                hz.flushd_o = hz.pcsrce_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_busy) begin
                        state <= WAIT;
                        cnt   <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (stallf && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.stallf_o     = stallf;
    assign hz.stall_cnt_o  = stall_cnt;
    assign hz.wait_state_o = (state == WAIT);
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: dut_a uses a 2-cycle memory wait, dut_b single-cycle memory
// with a 4-bit stall counter; both see the same pipeline inputs.
module tb_hazard_controller;
    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, pcsrce, regwritem, memaccessm, regwritew;

    hazard_controller_if #(.CNT_W(32)) ia ();
    hazard_controller_if #(.CNT_W(4))  ib ();

    assign ia.rs1d_i = rs1d;  assign ib.rs1d_i = rs1d;
    assign ia.rs2d_i = rs2d;  assign ib.rs2d_i = rs2d;
    assign ia.rs1e_i = rs1e;  assign ib.rs1e_i = rs1e;
    assign ia.rs2e_i = rs2e;  assign ib.rs2e_i = rs2e;
    assign ia.rde_i  = rde;   assign ib.rde_i  = rde;
    assign ia.loade_i = loade;           assign ib.loade_i = loade;
    assign ia.pcsrce_i = pcsrce;         assign ib.pcsrce_i = pcsrce;
    assign ia.rdm_i = rdm;               assign ib.rdm_i = rdm;
    assign ia.regwritem_i = regwritem;   assign ib.regwritem_i = regwritem;
    assign ia.memaccessm_i = memaccessm; assign ib.memaccessm_i = memaccessm;
    assign ia.rdw_i = rdw;               assign ib.rdw_i = rdw;
    assign ia.regwritew_i = regwritew;   assign ib.regwritew_i = regwritew;

    hazard_controller #(.MEM_WAIT(2), .CNT_W(32)) dut_a (.clk_i(clk), .reset_i(reset_n), .hz(ia));
    hazard_controller #(.MEM_WAIT(0), .CNT_W(4))  dut_b (.clk_i(clk), .reset_i(reset_n), .hz(ib));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        loade = 0; pcsrce = 0; regwritem = 0; memaccessm = 0; regwritew = 0;
    endtask

    // stall pattern of dut_a packed as {stallf,stalld,stalle,stallm,flushd,flushe,flushw}
    function automatic logic [6:0] pat_a();
        return {ia.stallf_o, ia.stalld_o, ia.stalle_o, ia.stallm_o,
                ia.flushd_o, ia.flushe_o, ia.flushw_o};
    endfunction

    function automatic logic [6:0] pat_b();
        return {ib.stallf_o, ib.stalld_o, ib.stalle_o, ib.stallm_o,
                ib.flushd_o, ib.flushe_o, ib.flushw_o};
    endfunction

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        // hazards present during reset must not leak out
        rdm = 5; regwritem = 1; rs1e = 5; loade = 1; rde = 7; rs2d = 7; pcsrce = 1; memaccessm = 1;
        #1;
        check("rst_pat", 32'(pat_a()), 32'h0);
        check("rst_fwd", 32'({ia.forwardae_o, ia.forwardbe_o}), 32'h0);
        check("rst_cnt", ia.stall_cnt_o, 32'd0);
        check("rst_state", 32'(ia.wait_state_o), 32'd0);
        step(); step();
        clear_inputs();
        reset_n = 1'b1;
        #1;
        check("idle_pat", 32'(pat_a()), 32'h0);

        // forwarding
        rdm = 5; regwritem = 1; rdw = 5; regwritew = 1; rs1e = 5; rs2e = 5; #1;
        check("fwd_mem_a", 32'(ia.forwardae_o), 32'd2);
        check("fwd_mem_b", 32'(ia.forwardbe_o), 32'd2);
        regwritem = 0; #1;
        check("fwd_wb_a", 32'(ia.forwardae_o), 32'd1);
        regwritem = 1; rdm = 0; rdw = 0; rs1e = 0; rs2e = 0; #1;
        check("fwd_x0", 32'({ia.forwardae_o, ia.forwardbe_o}), 32'h0);
        rdm = 5; rs1e = 5; rdw = 3; rs2e = 3; #1;
        check("fwd_split", 32'({ia.forwardae_o, ia.forwardbe_o}), 32'b1001);
        check("fwd_pat", 32'(pat_a()), 32'h0);
        clear_inputs();

        // load-use
        loade = 1; rde = 7; rs2d = 7; #1;
        check("lw_pat", 32'(pat_a()), 32'b1100010);
        step();
        loade = 0; rde = 0; rs2d = 0; #1;
        check("lw_cnt_a", ia.stall_cnt_o, 32'd1);
        check("lw_cnt_b", 32'(ib.stall_cnt_o), 32'd1);
        check("lw_off", 32'(pat_a()), 32'h0);
        loade = 1; rde = 7; rs2d = 7; pcsrce = 1; #1;
        check("lw_br", 32'(pat_a()), 32'b0000110);
        step();
        rde = 0; rs1d = 0; rs2d = 0; pcsrce = 0; #1;
        check("lw_x0", 32'(pat_a()), 32'h0);
        check("lw_br_cnt", ia.stall_cnt_o, 32'd1);
        clear_inputs();

        // memory wait
        memaccessm = 1; #1;
        check("mw_c0_a", 32'(pat_a()), 32'b1111001);
        check("mw_c0_b", 32'(pat_b()), 32'h0);
        step();
        memaccessm = 0; #1;
        check("mw_c1_a", 32'(pat_a()), 32'b1111001);
        check("mw_c1_st", 32'(ia.wait_state_o), 32'd1);
        step();
        check("mw_c2_a", 32'(pat_a()), 32'h0);
        step();
        check("mw_idle", 32'(ia.wait_state_o), 32'd0);
        check("mw_cnt_a", ia.stall_cnt_o, 32'd3);
        check("mw_cnt_b", 32'(ib.stall_cnt_o), 32'd1);

        // branch during busy
        memaccessm = 1; pcsrce = 1; #1;
        check("br_busy0", 32'(pat_a()), 32'b1111001);
        check("br_b", 32'(pat_b()), 32'b0000110);
        step();
        memaccessm = 0; #1;
        check("br_busy1", 32'(pat_a()), 32'b1111001);
        step();
        check("br_release", 32'(pat_a()), 32'b0000110);
        step();
        pcsrce = 0; #1;

        // load-use during busy
        memaccessm = 1; loade = 1; rde = 7; rs2d = 7; #1;
        check("lwb_busy0", 32'(pat_a()), 32'b1111001);
        check("lwb_b", 32'(pat_b()), 32'b1100010);
        step();
        memaccessm = 0; #1;
        check("lwb_busy1", 32'(pat_a()), 32'b1111001);
        step();
        check("lwb_release", 32'(pat_a()), 32'b1100010);
        step();
        clear_inputs(); #1;
        check("lwb_cnt_a", ia.stall_cnt_o, 32'd8);
        check("lwb_cnt_b", 32'(ib.stall_cnt_o), 32'd4);

        // asynchronous reset mid-wait
        memaccessm = 1; step();
        memaccessm = 0; #1;
        check("ar_pre_st", 32'(ia.wait_state_o), 32'd1);
        check("ar_pre_cnt", ia.stall_cnt_o, 32'd9);
        #2 reset_n = 1'b0;
        #1;
        check("ar_pat", 32'(pat_a()), 32'h0);
        check("ar_state", 32'(ia.wait_state_o), 32'd0);
        step();
        reset_n = 1'b1; #1;
        check("ar_post_pat", 32'(pat_a()), 32'h0);
        check("ar_post_cnt", ia.stall_cnt_o, 32'd0);
        step();
        check("ar_post_st", 32'(ia.wait_state_o), 32'd0);

        // saturation of the 4-bit counter
        loade = 1; rde = 7; rs1d = 7;
        for (int i = 0; i < 10; i++) step();
        check("sat_mid", 32'(ib.stall_cnt_o), 32'd10);
        for (int i = 0; i < 10; i++) step();
        check("sat_end", 32'(ib.stall_cnt_o), 32'd15);
        check("sat_a", ia.stall_cnt_o, 32'd20);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
